// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter sharing one data-memory port between NUM_CORES requesters.
// Define DM_ARB_FIXED_PRIO_EN for fixed priority (core 0 highest) instead.
module dm_access_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   pick;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

`ifdef DM_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (req[i]) pick = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W:0]   cand;
  logic             hit;

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_CORES; first set req wins.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CORES)) begin
        cand = cand - (IDX_W+1)'(NUM_CORES);
      end
      if (!hit && req[cand[IDX_W-1:0]]) begin
        hit  = 1'b1;
        pick = cand[IDX_W-1:0];
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef DM_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          we_d    = we[pick];
          addr_d  = addr[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d = wdata[int'(pick)*DATA_W +: DATA_W];
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifndef DM_ARB_FIXED_PRIO_EN
        rr_ptr_d = (gnt_q == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifndef DM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifndef DM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Latched regs only change on a grant, so they hold outside ACCESS.
  always_comb begin
    ack = '0;
    if (state_q == DONE) ack[gnt_q] = 1'b1;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter (NUM_CORES=4, MEM_LAT=2).
// Table vectors cover reset/read/write; sequences cover RR, mid-access and reset.
module tb_dm_access_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [3:0]  ack;
  logic [15:0] rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dm_access_arbiter #(
    .NUM_CORES(4),
    .ADDR_W(16),
    .DATA_W(16),
    .MEM_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .ack(ack),
    .rdata(rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [15:0] mrd;
    logic [3:0]  ack;
    logic        busy;
    logic        mwe;
    logic [15:0] maddr;
    logic [15:0] mwd;
    logic [15:0] rd;
  } vec_t;

  vec_t tv[10];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] A1 = 64'h0000_0000_0010_0000;
  localparam logic [63:0] A2 = 64'h0000_0ABC_0000_0000;
  localparam logic [63:0] W2 = 64'h0000_1234_0000_0000;

  int n;
  int eg;
  logic [3:0] eack;
  logic       ebusy;

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;

    tv[0] = '{1'b1, 4'b0000, 4'b0000, 64'h0, 64'h0, 16'h0,
              4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    tv[1] = tv[0];
    tv[2] = '{1'b0, 4'b0010, 4'b0000, A1, 64'h0, 16'hBEEF,
              4'b0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000};
    tv[3] = tv[2];
    tv[4] = '{1'b0, 4'b0010, 4'b0000, A1, 64'h0, 16'hBEEF,
              4'b0010, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tv[5] = '{1'b0, 4'b0000, 4'b0000, A1, 64'h0, 16'hBEEF,
              4'b0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tv[6] = '{1'b0, 4'b0100, 4'b0100, A2, W2, 16'h5555,
              4'b0000, 1'b1, 1'b1, 16'h0ABC, 16'h1234, 16'hBEEF};
    tv[7] = tv[6];
    tv[8] = '{1'b0, 4'b0100, 4'b0100, A2, W2, 16'h5555,
              4'b0100, 1'b1, 1'b0, 16'h0ABC, 16'h1234, 16'hBEEF};
    tv[9] = '{1'b0, 4'b0000, 4'b0000, A2, W2, 16'h5555,
              4'b0000, 1'b0, 1'b0, 16'h0ABC, 16'h1234, 16'hBEEF};

    for (int i = 0; i < 10; i++) begin
      rst = tv[i].rst; req = tv[i].req; we = tv[i].we;
      addr = tv[i].addr; wdata = tv[i].wdata; mem_rdata = tv[i].mrd;
      step();
      check($sformatf("v%0d_ack", i), ack, tv[i].ack);
      check($sformatf("v%0d_busy", i), busy, tv[i].busy);
      check($sformatf("v%0d_mem_we", i), mem_we, tv[i].mwe);
      check($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].maddr);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, tv[i].mwd);
      check($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
    end

    // Continuous requests: ack every 4 cycles, busy low only after ack.
    rst = 1'b1; req = '0; we = '0;
    addr = {16'h0333, 16'h0222, 16'h0111, 16'h0100};
    step(); step();
    rst = 1'b0;
`ifdef DM_ARB_FIXED_PRIO_EN
    req = 4'b1010;
`else
    req = 4'b1111;
`endif
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
`ifdef DM_ARB_FIXED_PRIO_EN
      eg = 1;
`else
      eg = (c / 4) % 4;
`endif
      eack  = (c % 4 == 3) ? 4'(1 << eg) : 4'b0000;
      ebusy = (c % 4 != 0);
      check($sformatf("rr_c%0d_ack", c), ack, eack);
      check($sformatf("rr_c%0d_busy", c), busy, ebusy);
      if (c % 4 == 3) begin
        check($sformatf("rr_c%0d_addr", c), mem_addr, addr[eg*16 +: 16]);
      end
      if (ack[3]) n++;
    end
`ifdef DM_ARB_FIXED_PRIO_EN
    check("fp_core3_acks", n, 0);
`else
    check("rr_core3_acks", n, 1);
`endif

    // Mid-access change of addr and req is ignored.
    rst = 1'b1; req = '0; we = '0; addr = '0;
    step(); step();
    rst = 1'b0; req = 4'b0001; addr = 64'h0005;
    step();
    check("mid_addr1", mem_addr, 16'h0005);
    check("mid_busy1", busy, 1'b1);
    addr = 64'h0FFF; req = 4'b0000;
    step();
    check("mid_addr2", mem_addr, 16'h0005);
    step();
    check("mid_ack", ack, 4'b0001);
    check("mid_addr3", mem_addr, 16'h0005);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack != 4'b0000) n++;
    end
    check("mid_no_extra_ack", n, 0);

    // Reset in the second ACCESS cycle aborts; re-grant starts from core0.
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    step(); step();
    rst = 1'b0; req = 4'b0010; addr = 64'h0020_0000;
    step(); step(); step();
    check("rm_pre_ack", ack, 4'b0010);
    req = 4'b1001; we = 4'b1000;
    addr = {16'h0033, 16'h0000, 16'h0000, 16'h0044};
    wdata = {16'h7777, 48'h0};
    step();
    check("rm_idle_busy", busy, 1'b0);
    step();
`ifdef DM_ARB_FIXED_PRIO_EN
    check("rm_acc_addr", mem_addr, 16'h0044);
    check("rm_acc_we", mem_we, 1'b0);
`else
    check("rm_acc_addr", mem_addr, 16'h0033);
    check("rm_acc_we", mem_we, 1'b1);
`endif
    step();
    check("rm_acc2_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    check("rm_rst_ack", ack, 4'b0000);
    check("rm_rst_busy", busy, 1'b0);
    check("rm_rst_we", mem_we, 1'b0);
    check("rm_rst_addr", mem_addr, 16'h0000);
    rst = 1'b0;
    step();
    check("rm_regrant_addr", mem_addr, 16'h0044);
    check("rm_regrant_we", mem_we, 1'b0);
    step();
    check("rm_regrant_noack", ack, 4'b0000);
    step();
    check("rm_regrant_ack", ack, 4'b0001);
    req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Shares the single data-memory address/data port between NUM_CORES per-core address registers (AR) and their write-data paths.
- Grants one core at a time using round-robin.
- Holds the granted core's address, write data and write enable stable for a fixed memory access window.
- Returns read data and a one-cycle ack to the granted core, then re-arbitrates.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, data-memory address width (matches AR DMADDR).
- DATA_W, 16, data-memory word width.
- MEM_LAT, 2, cycles the memory port is held per access (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_CORES  per-core access request, held high until ack.
- we  input  NUM_CORES  per-core write enable (1 = write, 0 = read), valid with req.
- addr  input  NUM_CORES*ADDR_W  per-core DMADDR; core i at bits [i*ADDR_W +: ADDR_W].
- wdata  input  NUM_CORES*DATA_W  per-core write data; same packing as addr.
- ack  output  NUM_CORES  one-hot, one-cycle completion pulse.
- rdata  output  DATA_W  read data returned to the granted core; valid when its ack is high.
- mem_addr  output  ADDR_W  address to data memory.
- mem_wdata  output  DATA_W  write data to data memory.
- mem_we  output  1  write strobe to data memory.
- mem_rdata  input  DATA_W  data memory read port.
- busy  output  1  high while in ACCESS or DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=0, grant index=0.
  - ack=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0.
  - Reset mid-access aborts the access with no ack; the aborted core must re-request.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... (mod NUM_CORES).
  - Latch the grant index, addr, wdata and we of that core into internal registers.
  - Load cnt=MEM_LAT-1 and go to ACCESS. If no req, stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers; mem_we = latched we for every ACCESS cycle.
  - Outside ACCESS, mem_addr/mem_wdata hold their last value and mem_we=0.
  - cnt decrements each cycle. When cnt==0: capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to DONE.
- DONE:
  - ack[grant]=1 for exactly this cycle.
  - Set rr_ptr=(grant+1) mod NUM_CORES and go to IDLE.
- Latency: req sampled in IDLE at cycle 0 -> ACCESS cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1. The next grant is decided in cycle MEM_LAT+2.
- Requester rules:
  - Hold req, we, addr and wdata until ack.
  - Drop req in the cycle after ack, or keep it high to request again; it then competes round-robin.
- Inputs are sampled only in IDLE. Changes to the granted core's addr, wdata or req during ACCESS or DONE are ignored; the access completes and ack still pulses.
- Simultaneous requests are resolved by rr_ptr only. No starvation: any core holding req is served within NUM_CORES grants.
- rr_ptr wrap-around: grant index NUM_CORES-1 -> rr_ptr=0.
- ack is never asserted in IDLE or ACCESS. Bits of ack other than the grant index are always 0.

Optional Feature:
- DM_ARB_FIXED_PRIO_EN.
- Defined: IDLE selects the lowest-index set req bit (core 0 highest priority); rr_ptr is not implemented or updated. Starvation of high-index cores is permitted.
- Undefined: round-robin as specified above.
- Timing and all other behaviour are identical in both builds.

Test Plan (NUM_CORES=4, MEM_LAT=2):
- Reset: after rst=1 for 2 cycles -> ack=0000, mem_we=0, busy=0, rdata=0. Then core1 requests a read at addr 0x0010 with mem_rdata=0xBEEF -> ack=0010 exactly 3 cycles after the req-sampling edge, rdata=0xBEEF.
- Write: core2 we=1, addr 0x0ABC, wdata 0x1234 -> mem_we=1 for exactly 2 cycles with mem_addr=0x0ABC and mem_wdata=0x1234, then ack=0100. rdata is unchanged.
- Round-robin: all four req held high continuously from reset -> grant order 0,1,2,3,0. Acks are 4 cycles apart; busy is low only in the IDLE cycles between accesses.
- Mid-access change: core0's addr changes from 0x0005 to 0x0FFF and req drops during ACCESS -> mem_addr stays 0x0005 and ack[0] still pulses once.
- Reset mid-access: rst asserted in the second ACCESS cycle -> no ack, state IDLE, mem_we=0 in the next cycle. A pending req is then served starting from core0.
- With DM_ARB_FIXED_PRIO_EN defined: req 1010 held continuously -> core1 is granted every time and core3 never receives ack.
